// File: rtl/mcdp_pkg.sv
// mcdp_pkg: opcodes, funct codes, FSM states and ALU ops for the multicycle datapath
package mcdp_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK} state_t;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_BAD} alu_op_t;

    // beq uses SUB so the ALU zero result drives the branch decision
    function automatic alu_op_t alu_op(input logic [5:0] op, input logic [5:0] funct);
        if (op == OP_RTYPE)
            return funct == FN_ADD ? ALU_ADD : funct == FN_SUB ? ALU_SUB :
                   funct == FN_AND ? ALU_AND : funct == FN_OR ? ALU_OR :
                   funct == FN_SLT ? ALU_SLT : ALU_BAD;
        return (op == OP_ADDI || op == OP_LW || op == OP_SW) ? ALU_ADD :
               op == OP_BEQ ? ALU_SUB : ALU_BAD;
    endfunction
endpackage

// File: rtl/mcdp_regfile.sv
// mcdp_regfile: register file with two async read ports, one sync write port, r0 hardwired to 0
module mcdp_regfile #(
    parameter int WIDTH = 16,
    parameter int REG_COUNT = 8,
    localparam int RA_W = $clog2(REG_COUNT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [RA_W-1:0]  ra,
    input  logic [RA_W-1:0]  rb,
    output logic [WIDTH-1:0] da,
    output logic [WIDTH-1:0] db,
    input  logic             we,
    input  logic [RA_W-1:0]  wa,
    input  logic [WIDTH-1:0] wd
);
    logic [WIDTH-1:0] regs [REG_COUNT];

    assign da = regs[ra];
    assign db = regs[rb];

    // r0 is never written, so it keeps its reset value of zero
    always_ff @(posedge clock or posedge reset)
        if (reset)
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        else if (we && wa != '0)
            regs[wa] <= wd;
endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: five-state multicycle CPU datapath with regfile, ALU and handshaked memory port
module multicycle_datapath
    import mcdp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int REG_COUNT = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack,
    output logic [WIDTH-1:0]  result,
    output logic              result_valid,
    output logic              branch_taken,
    output logic [WIDTH-1:0]  pc,
    output logic              illegal,
    output logic              busy
);
    localparam int RA_W = $clog2(REG_COUNT);

    state_t           state, state_n;
    alu_op_t          aop;
    logic [31:0]      ir;
    logic [5:0]       op;
    logic [WIDTH-1:0] a, b, rd_a, rd_b, imm_x, opnd, alu;
    logic             rf_we, is_mem, unused_bits;

    assign op          = ir[31:26];
    assign aop         = alu_op(op, ir[5:0]);
    assign is_mem      = op == OP_LW || op == OP_SW;
    assign imm_x       = {{(WIDTH-16){ir[15]}}, ir[15:0]};
    assign opnd        = (op == OP_RTYPE || op == OP_BEQ) ? b : imm_x;
    assign mem_addr    = result[ADDR_W-1:0];
    assign mem_wdata   = b;
    assign unused_bits = ^ir;

    mcdp_regfile #(.WIDTH(WIDTH), .REG_COUNT(REG_COUNT)) u_rf (
        .clock(clock),
        .reset(reset),
        .ra(ir[21 +: RA_W]),
        .rb(ir[16 +: RA_W]),
        .da(rd_a),
        .db(rd_b),
        .we(rf_we),
        .wa(op == OP_RTYPE ? ir[11 +: RA_W] : ir[16 +: RA_W]),
        .wd(result)
    );

    // ALU: all arithmetic wraps modulo 2^WIDTH
    always_comb
        alu = aop == ALU_SUB ? a - opnd :
              aop == ALU_AND ? a & opnd :
              aop == ALU_OR  ? a | opnd :
              aop == ALU_SLT ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(opnd)} :
              a + opnd;

    // Next-state and per-state strobes; memory outputs derive from state so reset drops them at once
    always_comb begin
        state_n      = state;
        instr_ready  = 1'b0;
        busy         = 1'b1;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        result_valid = 1'b0;
        branch_taken = 1'b0;
        illegal      = 1'b0;
        rf_we        = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                state_n     = instr_valid ? S_DECODE : S_IDLE;
            end
            S_DECODE: state_n = S_EXECUTE;
            S_EXECUTE: begin
                illegal      = aop == ALU_BAD;
                branch_taken = op == OP_BEQ && alu == '0;
                state_n      = (aop == ALU_BAD || op == OP_BEQ) ? S_IDLE : is_mem ? S_MEM : S_WRITEBACK;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = op == OP_SW;
                state_n = !mem_ack ? S_MEM : op == OP_SW ? S_IDLE : S_WRITEBACK;
            end
            S_WRITEBACK: begin
                result_valid = 1'b1;
                rf_we        = 1'b1;
                state_n      = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, instruction latch, operand latches, pc and result register (ALU value or load data)
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state  <= S_IDLE;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            result <= '0;
            pc     <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && instr_valid) begin
                ir <= instr;
                pc <= pc + WIDTH'(1);
            end
            if (state == S_DECODE) begin
                a <= rd_a;
                b <= rd_b;
            end
            if (state == S_EXECUTE) begin
                result <= alu;
                if (branch_taken) pc <= pc + imm_x;
            end
            if (state == S_MEM && mem_ack) result <= mem_rdata;
        end
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: random and directed checks against an instruction-level reference model
module tb_multicycle_datapath;
    logic        clock = 0, reset = 0;
    logic [31:0] instr, instr2;
    logic        instr_valid, instr_valid2;
    logic        instr_ready, mem_req, mem_we, result_valid, branch_taken, illegal, busy, mem_ack;
    logic [7:0]  mem_addr, mem_addr2;
    logic [15:0] mem_wdata, mem_rdata, result, pc;
    logic        instr_ready2, mem_req2, mem_we2, result_valid2, branch_taken2, illegal2, busy2;
    logic [31:0] mem_wdata2, result2, pc2;

    always #5 clock = ~clock;

    multicycle_datapath dut (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .result(result),
        .result_valid(result_valid), .branch_taken(branch_taken), .pc(pc), .illegal(illegal), .busy(busy)
    );

    multicycle_datapath #(.WIDTH(32), .REG_COUNT(16)) dut32 (
        .clock(clock), .reset(reset), .instr(instr2), .instr_valid(instr_valid2),
        .instr_ready(instr_ready2), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(32'd0), .mem_ack(1'b1), .result(result2),
        .result_valid(result_valid2), .branch_taken(branch_taken2), .pc(pc2), .illegal(illegal2), .busy(busy2)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: architectural registers, memory, pc and per-instruction expectations
    logic [15:0] R [8];
    logic [15:0] M [256];
    logic [15:0] mpc, e_res, e_wdata, e_pc, last_res;
    logic [7:0]  e_addr;
    int          kind, lat, done_rel, dly, t0, last_rel, mreq_cnt;
    bit          e_taken, e_lw, act = 0;
    int          cyc = 0;

    always @(posedge clock) cyc++;

    // Memory responder: ack after dly stalled cycles; spurious acks while no request is pending
    int wcnt = 0;
    always @(negedge clock)
        if (mem_req) begin
            mem_ack   = wcnt == dly;
            mem_rdata = M[mem_addr];
            wcnt++;
        end else begin
            wcnt      = 0;
            mem_ack   = $urandom_range(3) == 0;
            mem_rdata = 16'($urandom);
        end

    // Compare process: every output checked every cycle of an instruction against the model timeline
    always @(negedge clock) begin
        int rel;
        bit ev, mv;
        if (act && !reset) begin
            rel = cyc - t0;
            if (result_valid) begin
                last_res = result;
                last_rel = rel;
            end
            if (mem_req) mreq_cnt++;
            if (rel > 0) begin
                ev = kind == 0 && rel == lat;
                chk("result_valid", result_valid, ev);
                if (ev) chk("result", result, e_res);
                chk("branch_taken", branch_taken, kind == 2 && e_taken && rel == 2);
                chk("illegal", illegal, kind == 3 && rel == 2);
                mv = (kind == 1 || e_lw) && rel >= 3 && rel <= 3 + dly;
                chk("mem_req", mem_req, mv);
                if (mv) begin
                    chk("mem_addr", mem_addr, e_addr);
                    chk("mem_we", mem_we, kind == 1);
                    if (kind == 1) chk("mem_wdata", mem_wdata, e_wdata);
                end
                chk("instr_ready", instr_ready, rel > done_rel);
                chk("busy", busy, rel <= done_rel);
                if (rel > done_rel) chk("pc", pc, e_pc);
            end
        end
    end

    function automatic logic [31:0] rtype(int rs, int rt, int rd, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Evaluate one instruction in the model, then drive it and keep the bus noisy while busy
    task automatic issue(input logic [31:0] iw, input int d);
        logic [15:0] a, b, imm, v, s;
        logic [5:0]  op, fn;
        int          dest;
        op = iw[31:26]; fn = iw[5:0]; imm = iw[15:0];
        a = R[iw[23:21]]; b = R[iw[18:16]];
        mpc = mpc + 1;
        kind = 3; e_lw = 0; e_taken = 0; dest = 0; lat = 3; v = 0; dly = d;
        s = a + imm;
        e_addr = s[7:0];
        if (op == 0) begin
            kind = 0;
            dest = int'(iw[13:11]);
            case (fn)
                32: v = a + b;
                34: v = a - b;
                36: v = a & b;
                37: v = a | b;
                42: v = $signed(a) < $signed(b) ? 16'd1 : 16'd0;
                default: kind = 3;
            endcase
        end else if (op == 8) begin
            kind = 0; v = s; dest = int'(iw[18:16]);
        end else if (op == 35) begin
            kind = 0; e_lw = 1; v = M[e_addr]; dest = int'(iw[18:16]); lat = 4 + d;
        end else if (op == 43) begin
            kind = 1; M[e_addr] = b; e_wdata = b;
        end else if (op == 4) begin
            kind = 2; e_taken = a == b;
            if (e_taken) mpc = mpc + imm;
        end
        if (kind == 0 && dest != 0) R[dest] = v;
        done_rel = kind == 0 ? lat : kind == 1 ? 3 + d : 2;
        e_res = v; e_pc = mpc;
        instr = iw; instr_valid = 1; t0 = cyc; act = 1;
        while (cyc - t0 <= done_rel) begin
            @(negedge clock);
            #1;
            instr_valid = 1'($urandom_range(1));
            instr = $urandom;
        end
        instr_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic issue2(input logic [31:0] iw, input logic [31:0] exp, input string name);
        int k = 0;
        instr2 = iw; instr_valid2 = 1;
        while (result_valid2 !== 1'b1 && k < 10) begin
            @(negedge clock);
            instr_valid2 = 0;
            k++;
        end
        chk(name, result2, {32'd0, exp});
        chk({name, "_lat"}, k, 3);
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL timeout: bench did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int fns[5] = '{32, 34, 36, 37, 42};
        int bad_ops[4] = '{63, 1, 15, 50};
        instr = 0; instr_valid = 0; instr2 = 0; instr_valid2 = 0;
        foreach (M[i]) M[i] = 16'($urandom);
        foreach (R[i]) R[i] = 0;
        mpc = 0;
        #1 reset = 1;
        #2;
        chk("rst_ready", instr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_branch", branch_taken, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_pc", pc, 0);
        chk("rst_result", result, 0);
        chk("rst_ready32", instr_ready2, 1);
        repeat (2) @(negedge clock);
        reset = 0;
        #1;

        issue(itype(8, 0, 1, 5), 0);  chk("addi_r1", last_res, 5);  chk("addi_lat", last_rel, 3);
        issue(itype(8, 0, 2, 3), 0);  chk("addi_r2", last_res, 3);
        issue(rtype(1, 2, 3, 32), 0); chk("add_r3", last_res, 8);   chk("add_lat", last_rel, 3);
        issue(rtype(2, 1, 4, 34), 0); chk("sub_r4", last_res, 16'hFFFE);
        issue(rtype(4, 0, 5, 42), 0); chk("slt_r5", last_res, 1);
        issue(itype(4, 1, 1, -2), 0); chk("beq_pc", pc, 4);
        issue(itype(63, 1, 1, 77), 0);
        issue(itype(8, 1, 7, 0), 0);  chk("illegal_nochange", last_res, 5);
        mreq_cnt = 0;
        issue(itype(43, 0, 3, 2), 3); chk("sw_req_cycles", mreq_cnt, 4);
        issue(itype(35, 0, 6, 2), 3); chk("lw_r6", last_res, 8);    chk("lw_lat", last_rel, 7);

        for (int n = 0; n < 300; n++) begin
            int r, rs, rt;
            r = $urandom_range(9); rs = $urandom_range(31); rt = $urandom_range(31);
            case (r)
                4:       issue(itype(8, rs, rt, $urandom), 0);
                5:       issue(itype(35, rs, rt, $urandom), $urandom_range(4));
                6:       issue(itype(43, rs, rt, $urandom), $urandom_range(4));
                7:       issue(itype(4, rs, $urandom_range(1) ? rs : rt, $urandom_range(15) - 8), 0);
                8:       issue(itype(bad_ops[$urandom_range(3)], rs, rt, $urandom), 0);
                9:       issue(rtype(rs, rt, $urandom_range(31), $urandom_range(1) ? 0 : 63), 0);
                default: issue(rtype(rs, rt, $urandom_range(31), fns[$urandom_range(4)]), 0);
            endcase
            idle($urandom_range(2));
        end

        act = 0;
        dly = 1000;
        instr = itype(43, 0, 3, 5); instr_valid = 1;
        repeat (3) begin
            @(negedge clock);
            #1 instr_valid = 0;
        end
        chk("mem_req_pre_reset", mem_req, 1);
        reset = 1;
        #1;
        chk("mid_mem_req", mem_req, 0);
        chk("mid_mem_we", mem_we, 0);
        chk("mid_ready", instr_ready, 1);
        chk("mid_busy", busy, 0);
        chk("mid_pc", pc, 0);
        foreach (R[i]) R[i] = 0;
        mpc = 0;
        @(negedge clock);
        reset = 0;
        #1;
        idle(3);
        chk("post_reset_ready", instr_ready, 1);
        for (int i = 1; i < 8; i++) begin
            issue(itype(8, i, i, 0), 0);
            chk("reg_cleared", last_res, 0);
        end

        @(negedge clock);
        issue2(itype(8, 0, 1, -1), 32'hFFFFFFFF, "w32_addi_m1");
        issue2(itype(8, 0, 2, 1), 32'd1, "w32_addi_1");
        issue2(rtype(1, 2, 3, 32), 32'd0, "w32_add_wrap");
        issue2(itype(8, 0, 0, 9), 32'd9, "w32_r0_write");
        issue2(rtype(0, 0, 4, 32), 32'd0, "w32_r0_read");
        issue2(itype(8, 0, 15, 7), 32'd7, "w32_r15_write");
        issue2(rtype(15, 0, 5, 32), 32'd7, "w32_r15_read");
        issue2(rtype(17, 0, 6, 32), 32'hFFFFFFFF, "w32_rs_low_bits");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
